// File: rtl/imem_boot_loader.sv
// Boot-time instruction loader and instruction RAM.
// Streams 32-bit words into a word-addressed RAM and holds the processor in
// reset until the program is in place. It then releases the processor and
// serves combinational instruction fetches.
module imem_boot_loader #(
  parameter int          DEPTH      = 64,
  parameter logic [63:0] START_PC   = 64'h0,
  parameter int          RESET_HOLD = 2
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  input  logic [63:0]              currentpc,
  output logic [31:0]              instruction,
  output logic [63:0]              startpc,
  output logic                     proc_resetl,
  output logic [$clog2(DEPTH):0]   loaded_words,
  output logic                     done,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(RESET_HOLD + 1);

  localparam logic [AW:0]   LW_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   LW_LAST   = (AW+1)'(DEPTH - 1);
  localparam logic [HW-1:0] CNT_ONE   = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [63:0]   PC_LIMIT  = 64'(4 * DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   cnt_q, cnt_d;
  logic            ld_ready_q, ld_ready_d;
  logic            proc_resetl_q, proc_resetl_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [AW:0]     lw_q, lw_d;

  logic [31:0]     mem [DEPTH];
  logic            wr_en;
  logic            last_slot;

  // A word is taken only while loading; a simultaneous reset suppresses it.
  assign wr_en     = (state_q == S_LOAD) && ld_valid && ld_ready_q && !reset;
  assign last_slot = (lw_q == LW_LAST);

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ld_ready_d    = ld_ready_q;
    proc_resetl_d = proc_resetl_q;
    done_d        = done_q;
    err_d         = err_q;
    lw_d          = lw_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        // A (re)load request puts the processor back into reset right away.
        if (load_start) begin
          state_d       = S_LOAD;
          ld_ready_d    = 1'b1;
          proc_resetl_d = 1'b0;
          done_d        = 1'b0;
          err_d         = 1'b0;
          lw_d          = '0;
        end
      end
      S_LOAD: begin
        if (wr_en) begin
          lw_d = lw_q + LW_ONE;
          // The last RAM slot ends the load even without ld_last; flag truncation.
          if (ld_last || last_slot) begin
            state_d    = S_HOLD;
            ld_ready_d = 1'b0;
            cnt_d      = '0;
            err_d      = !ld_last;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d       = S_RUN;
          proc_resetl_d = 1'b1;
          done_d        = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ld_ready_q    <= 1'b0;
      proc_resetl_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      lw_q          <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ld_ready_q    <= ld_ready_d;
      proc_resetl_q <= proc_resetl_d;
      done_q        <= done_d;
      err_q         <= err_d;
      lw_q          <= lw_d;
    end
  end

  // Instruction RAM write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[lw_q[AW-1:0]] <= ld_data;
    end
  end

  // Combinational fetch; PCs beyond the RAM read as zero, byte offset ignored.
  always_comb begin
    instruction = '0;
    if (currentpc < PC_LIMIT) begin
      instruction = mem[currentpc[AW+1:2]];
    end
  end

  assign ld_ready     = ld_ready_q;
  assign proc_resetl  = proc_resetl_q;
  assign done         = done_q;
  assign err          = err_q;
  assign loaded_words = lw_q;
  assign startpc      = START_PC;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a 64-word and a 16-word instance share one
// stimulus stream. Both are compared every cycle against a timeline model.
module tb_imem_boot_loader;

  localparam int RH = 2;

  logic        CLK = 1'b0;
  logic        reset, load_start, ld_valid, ld_last;
  logic [31:0] ld_data;
  logic [63:0] currentpc;

  logic        rdy [2];
  logic [31:0] ins [2];
  logic [63:0] spc [2];
  logic        prl [2];
  logic        dn  [2];
  logic        er  [2];
  logic [6:0]  lw0;
  logic [4:0]  lw1;

  always #5 CLK = ~CLK;

  imem_boot_loader #(.DEPTH(64), .START_PC(64'h0), .RESET_HOLD(RH)) dut64 (
    .CLK(CLK), .reset(reset), .load_start(load_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(rdy[0]), .currentpc(currentpc),
    .instruction(ins[0]), .startpc(spc[0]), .proc_resetl(prl[0]),
    .loaded_words(lw0), .done(dn[0]), .err(er[0]));

  imem_boot_loader #(.DEPTH(16), .START_PC(64'h0), .RESET_HOLD(RH)) dut16 (
    .CLK(CLK), .reset(reset), .load_start(load_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(rdy[1]), .currentpc(currentpc),
    .instruction(ins[1]), .startpc(spc[1]), .proc_resetl(prl[1]),
    .loaded_words(lw1), .done(dn[1]), .err(er[1]));

  // Reference model: load progress plus the edge of the final handshake.
  int          depth [2] = '{64, 16};
  bit          m_load [2];
  int          m_words [2];
  int          m_fin [2];
  bit          m_err [2];
  logic [31:0] m_mem [2][64];
  bit          m_val [2][64];
  int          cyc;
  int          vectors;
  int          miscompares;

  logic [31:0] prog [13];
  logic [31:0] w5 [5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rand_pc();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 64'($urandom_range(0, 255));
    else if (r == 7) return ($urandom_range(0, 1) == 0) ? 64'd64 : 64'd256;
    else return {$urandom, $urandom};
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit run;
      run = (m_fin[i] >= 0) && (cyc - m_fin[i] >= RH);
      chk($sformatf("ld_ready%0d", i), 64'(rdy[i]), 64'(m_load[i]));
      chk($sformatf("proc_resetl%0d", i), 64'(prl[i]), 64'(run));
      chk($sformatf("done%0d", i), 64'(dn[i]), 64'(run));
      chk($sformatf("err%0d", i), 64'(er[i]), 64'(m_err[i]));
      chk($sformatf("startpc%0d", i), spc[i], 64'h0);
      if (currentpc >= 64'(4 * depth[i])) begin
        chk($sformatf("instr_oor%0d", i), 64'(ins[i]), 64'h0);
      end else if (m_val[i][int'(currentpc >> 2)]) begin
        chk($sformatf("instr%0d", i), 64'(ins[i]), 64'(m_mem[i][int'(currentpc >> 2)]));
      end
    end
    chk("loaded_words0", 64'(lw0), 64'(m_words[0]));
    chk("loaded_words1", 64'(lw1), 64'(m_words[1]));
  endtask

  // Advance the model by one edge using the current inputs, clock, then compare.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_load[i] = 1'b0; m_words[i] = 0; m_fin[i] = -1; m_err[i] = 1'b0;
      end else if (m_load[i]) begin
        if (ld_valid) begin
          m_mem[i][m_words[i]] = ld_data;
          m_val[i][m_words[i]] = 1'b1;
          m_words[i]++;
          if (ld_last || m_words[i] == depth[i]) begin
            m_load[i] = 1'b0;
            m_err[i]  = !ld_last;
            m_fin[i]  = cyc + 1;
          end
        end
      end else if (load_start && !(m_fin[i] >= 0 && cyc - m_fin[i] < RH)) begin
        m_load[i] = 1'b1; m_words[i] = 0; m_err[i] = 1'b0; m_fin[i] = -1;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic drive_idle();
    reset      = 1'b0;
    load_start = 1'b0;
    ld_valid   = 1'b0;
    ld_last    = 1'b0;
    ld_data    = $urandom;
    currentpc  = rand_pc();
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    for (int i = 0; i < 2; i++) begin
      m_load[i] = 1'b0; m_words[i] = 0; m_fin[i] = -1; m_err[i] = 1'b0;
      for (int j = 0; j < 64; j++) m_val[i][j] = 1'b0;
    end
    for (int j = 0; j < 12; j++) prog[j] = $urandom;
    prog[12] = 32'hF8000FE0;
    for (int j = 0; j < 5; j++) w5[j] = $urandom;

    // Reset held for two cycles.
    drive_idle();
    reset = 1'b1;
    step();
    step();
    chk("rst_proc_resetl", 64'(prl[0]), 64'h0);
    chk("rst_ld_ready", 64'(rdy[0]), 64'h0);
    chk("rst_done", 64'(dn[0]), 64'h0);
    chk("rst_err", 64'(er[0]), 64'h0);
    chk("rst_loaded_words", 64'(lw0), 64'h0);
    chk("rst_startpc", spc[0], 64'h0);

    // Normal back-to-back load of 13 words.
    drive_idle();
    load_start = 1'b1;
    step();
    chk("start_ld_ready", 64'(rdy[0]), 64'h1);
    for (int j = 0; j < 13; j++) begin
      drive_idle();
      ld_valid = 1'b1;
      ld_data  = prog[j];
      ld_last  = (j == 12);
      step();
    end
    chk("norm_ld_ready_off", 64'(rdy[0]), 64'h0);
    chk("norm_loaded_words", 64'(lw0), 64'd13);
    chk("norm_err", 64'(er[0]), 64'h0);
    drive_idle();
    step();
    chk("norm_hold1_resetl", 64'(prl[0]), 64'h0);
    drive_idle();
    step();
    chk("norm_release_resetl", 64'(prl[0]), 64'h1);
    chk("norm_release_done", 64'(dn[0]), 64'h1);
    drive_idle();
    currentpc = 64'h30;
    step();
    chk("norm_fetch_0x30", 64'(ins[0]), 64'hF8000FE0);

    // Reload from RUN, then stream the same program with gaps.
    drive_idle();
    load_start = 1'b1;
    step();
    chk("reload_resetl", 64'(prl[0]), 64'h0);
    chk("reload_done", 64'(dn[0]), 64'h0);
    chk("reload_ld_ready", 64'(rdy[0]), 64'h1);
    begin
      int idx;
      idx = 0;
      for (int k = 0; k < 40 && idx < 13; k++) begin
        drive_idle();
        ld_last = 1'($urandom_range(0, 1));
        if (k % 2 == 0) begin
          ld_valid = 1'b1;
          ld_data  = prog[idx];
          ld_last  = (idx == 12);
          idx++;
        end
        step();
      end
    end
    chk("stall_loaded_words", 64'(lw0), 64'd13);
    chk("stall_resetl_low", 64'(prl[0]), 64'h0);
    drive_idle();
    step();
    chk("stall_hold1_resetl", 64'(prl[0]), 64'h0);
    drive_idle();
    step();
    chk("stall_release_resetl", 64'(prl[0]), 64'h1);
    for (int j = 0; j < 13; j++) begin
      drive_idle();
      currentpc = 64'(j * 4 + $urandom_range(0, 3));
      step();
      chk($sformatf("stall_ram64_%0d", j), 64'(ins[0]), 64'(prog[j]));
      chk($sformatf("stall_ram16_%0d", j), 64'(ins[1]), 64'(prog[j]));
    end

    // Reset after five accepted words; reset also beats a load_start.
    drive_idle();
    load_start = 1'b1;
    step();
    for (int j = 0; j < 5; j++) begin
      drive_idle();
      ld_valid = 1'b1;
      ld_data  = w5[j];
      step();
    end
    drive_idle();
    reset      = 1'b1;
    load_start = 1'b1;
    step();
    chk("midrst_loaded_words", 64'(lw0), 64'h0);
    chk("midrst_resetl", 64'(prl[0]), 64'h0);
    chk("midrst_ld_ready", 64'(rdy[0]), 64'h0);
    drive_idle();
    currentpc = 64'd16;
    step();
    chk("midrst_ram4", 64'(ins[0]), 64'(w5[4]));

    // Twenty words without ld_last: the 16-deep instance truncates.
    drive_idle();
    load_start = 1'b1;
    step();
    for (int j = 0; j < 20; j++) begin
      drive_idle();
      ld_valid = 1'b1;
      step();
      if (j == 15) begin
        chk("ovf_ld_ready", 64'(rdy[1]), 64'h0);
        chk("ovf_err", 64'(er[1]), 64'h1);
        chk("ovf_loaded_words", 64'(lw1), 64'd16);
      end
    end
    chk("ovf_run_resetl", 64'(prl[1]), 64'h1);
    chk("ovf_run_done", 64'(dn[1]), 64'h1);
    chk("ovf_deep_loaded_words", 64'(lw0), 64'd20);

    // Reload from RUN on the small instance, then out-of-range fetches.
    drive_idle();
    load_start = 1'b1;
    currentpc  = 64'd64;
    step();
    chk("reload16_resetl", 64'(prl[1]), 64'h0);
    chk("reload16_done", 64'(dn[1]), 64'h0);
    chk("range16", 64'(ins[1]), 64'h0);
    drive_idle();
    currentpc = 64'd256;
    step();
    chk("range64", 64'(ins[0]), 64'h0);

    // Randomized traffic against the model.
    drive_idle();
    reset = 1'b1;
    step();
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 49) == 0);
      load_start = ($urandom_range(0, 7) == 0);
      ld_valid   = 1'($urandom_range(0, 1));
      ld_last    = ($urandom_range(0, 9) == 0);
      ld_data    = $urandom;
      currentpc  = rand_pc();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time instruction loader and instruction memory sitting directly upstream of `singlecycle`. It accepts 32-bit instruction words over a valid/ready stream and writes them into an internal word-addressed RAM. It holds the processor in reset until loading finishes, then releases it and drives its start PC. The processor fetches from this block by presenting `currentpc` and reading `instruction` combinationally.

## Interface
- `DEPTH`, 64: instruction RAM size in 32-bit words; power of two, ≥ 4.
- `START_PC`, 64'h0: value driven on `startpc`.
- `RESET_HOLD`, 2: cycles `proc_resetl` stays low after the final word is accepted; ≥ 1.

- `CLK` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `load_start` in 1: single-cycle request to begin a (re)load.
- `ld_valid` in 1: stream word valid.
- `ld_data` in 32: instruction word.
- `ld_last` in 1: qualifies the final word of the program.
- `ld_ready` out 1: loader accepts a word this cycle.
- `currentpc` in 64: processor PC, byte address.
- `instruction` out 32: RAM word at `currentpc`; combinational.
- `startpc` out 64: constant `START_PC`, to the processor.
- `proc_resetl` out 1: active-low reset to the processor.
- `loaded_words` out clog2(DEPTH)+1: number of words accepted in the current/last load.
- `done` out 1: program loaded, processor running.
- `err` out 1: truncation occurred in the last load.

## Operation
- States: IDLE, LOAD, HOLD, RUN. All outputs except `instruction` are registered.
- Reset, from any state: IDLE. Outputs after reset: `proc_resetl`=0, `ld_ready`=0, `loaded_words`=0, `done`=0, `err`=0, `startpc`=`START_PC`. RAM contents are not cleared.
- IDLE: `load_start`=1 → LOAD. `loaded_words` is cleared and `err` is cleared.
- LOAD:
  - `ld_ready`=1.
  - Each `ld_valid & ld_ready` edge writes `ld_data` to RAM[`loaded_words`] and increments `loaded_words`.
  - Accepted word with `ld_last`=1 → HOLD.
  - Accepted word at index DEPTH-1 with `ld_last`=0 → HOLD with `err`=1. No further words are accepted.
  - `load_start` is ignored.
- HOLD:
  - `ld_ready`=0, `proc_resetl`=0.
  - A counter runs RESET_HOLD cycles, then → RUN.
  - `load_start` is ignored.
- RUN:
  - `proc_resetl`=1, `done`=1.
  - `load_start`=1 → LOAD. `proc_resetl`=0 and `done`=0 from the next edge. `loaded_words` and `err` are cleared.
- Read path:
  - `instruction` = RAM[`currentpc`[clog2(DEPTH)+1:2]]. `currentpc`[1:0] is ignored.
  - If `currentpc` ≥ 4·DEPTH, `instruction`=32'h0.
  - Valid in every state.
- `ld_valid` outside LOAD has no effect. `ld_data` and `ld_last` are don't-care unless `ld_valid`=1.

## Timing
- `load_start` sampled at edge k: `ld_ready`=1 after edge k. The first word can be accepted at edge k+1.
- Throughput is one word per cycle, with no bubbles between accepted words.
- Final word accepted at edge n:
  - `ld_ready`=0 after edge n.
  - `proc_resetl` and `done` rise after edge n+RESET_HOLD.
- RAM write at edge e is visible on `instruction` immediately after edge e. Write-first; no read latency.
- `reset` asserted mid-LOAD or mid-HOLD: IDLE at that edge. Words already written remain in RAM; `loaded_words` reads 0.
- `load_start` and `reset` in the same cycle: `reset` wins.
- `load_start` in the same RUN cycle as a processor fetch: the fetch returns the old RAM contents; the processor is in reset from the next edge.

## Test plan
- Reset: hold `reset` 2 cycles → `proc_resetl`=0, `ld_ready`=0, `done`=0, `err`=0, `loaded_words`=0, `startpc`=0.
- Normal load: DEPTH=64, RESET_HOLD=2. Pulse `load_start`, then stream 13 words back-to-back (words 0..11 arbitrary, word 12 = 32'hF8000FE0 with `ld_last`) → `loaded_words`=13, `err`=0.
  - `proc_resetl` and `done` rise exactly 2 edges after the last handshake.
  - `currentpc`=64'h30 → `instruction`=32'hF8000FE0.
- Stalled stream: same program with `ld_valid` low every other cycle → identical RAM contents and `loaded_words`=13. Release occurs 2 cycles after the last handshake.
- Overflow: DEPTH=16, send 20 words without `ld_last` → 16 accepted, `ld_ready`=0 after the 16th, `err`=1. RUN is reached after RESET_HOLD.
- Reset mid-load: assert `reset` after 5 accepted words → IDLE, `loaded_words`=0, `proc_resetl`=0. RAM[4] still holds the 5th word.
- Reload and range: in RUN, pulse `load_start` → `proc_resetl`=0 and `done`=0 next cycle. `currentpc`=4·DEPTH → `instruction`=0.
